// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // RISC-V base instruction field positions and widths
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RD_W    = 5;
  localparam int F3_LSB  = 12;
  localparam int F3_W    = 3;
  localparam int RS1_LSB = 15;
  localparam int RS1_W   = 5;
  localparam int RS2_LSB = 20;
  localparam int RS2_W   = 5;
  localparam int F7_LSB  = 25;
  localparam int F7_W    = 7;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with first-word fall-through head.
// While empty, head shows the most recently popped entry.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    head_idx;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The slot behind the read pointer is the last entry popped; it is
  // never overwritten while empty because writes land at rd_ptr_q.
  assign head_idx = empty_o ? rd_ptr_q - AW'(1) : rd_ptr_q;
  assign head_o   = mem_q[head_idx];
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited PC sequencer, in-order buffer
// and field split for decode. Optional counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic              en_q;
  logic              hold_q, hold_d;
  logic [CW:0]       credit_used;
  logic              accept, pop;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   head_inst;

  // Handshake: a transfer happens on a cycle where valid && ready are both
  // high; once raised, valid and its payload hold until that cycle.
  always_comb begin
    credit_used    = {1'b0, out_q} + {1'b0, fifo_count};
    imem_req_valid = hold_q | (en_q & fetch_en & (credit_used < DEPTH_C));
    accept         = imem_req_valid & imem_req_ready;
    hold_d         = imem_req_valid & ~imem_req_ready;
    req_pc_d       = accept ? req_pc_q + XLEN'(4) : req_pc_q;
    rsp_pc_d       = imem_rsp_valid ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    out_d          = out_q;
    case ({accept, imem_rsp_valid})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      en_q     <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      en_q     <= 1'b1;
      hold_q   <= hold_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (imem_rsp_valid),
    .wdata_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && fifo_full));

  assign imem_req_addr = req_pc_q;
  assign inst_valid    = ~fifo_empty;
  assign pop           = inst_valid & inst_ready;
  assign inst_pc       = head[2*XLEN-1:XLEN];
  assign head_inst     = head[XLEN-1:0];
  assign opcode        = head_inst[OPC_LSB +: OPC_W];
  assign rd            = head_inst[RD_LSB  +: RD_W];
  assign funct3        = head_inst[F3_LSB  +: F3_W];
  assign rs1           = head_inst[RS1_LSB +: RS1_W];
  assign rs2           = head_inst[RS2_LSB +: RS2_W];
  assign funct7        = head_inst[F7_LSB  +: F7_W];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop)                       fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (inst_valid && !inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed/random bench for fetch_stage with a 1-cycle-latency memory model
// and an in-order scoreboard of {pc, word} pairs.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, imem_req_ready, imem_rsp_valid, inst_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_pc;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  logic        w_req_valid, w_inst_valid, w_inst_ready;
  logic [31:0] w_req_addr, w_inst_pc;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch, w_perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Second instance starting just below the 32-bit wrap; memory never answers.
  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(1'b1),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .inst_valid(w_inst_valid),
    .inst_ready(w_inst_ready), .inst_pc(w_inst_pc), .opcode(w_opcode), .rd(w_rd),
    .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2), .funct7(w_funct7)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] exp_addr, w_exp, last_pc, last_word, held_addr, obs_addr;
  int          m_out, m_cnt, acc_cnt, w_acc, pop_cnt, stall_cnt, a0;
  logic        m_en, m_hold, obs_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge+1, update model at posedge,
  // drive the memory response for the next cycle at the following negedge.
  task automatic tick();
    logic         exp_valid, acc, pop, rsp_now;
    fetch_entry_t e;
    logic [31:0]  a, d;
    #1;
    exp_valid = m_hold || (m_en && fetch_en && (m_out + m_cnt < DEPTH));
    chk("req_valid", imem_req_valid, exp_valid);
    obs_valid = imem_req_valid;
    obs_addr  = imem_req_addr;
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_addr);
      pend_q.push_back(exp_addr);
      exp_addr += 32'd4;
      acc_cnt++;
    end
    chk("inst_valid", inst_valid, m_cnt != 0);
    if (m_cnt != 0) begin
      e = exp_q[0];
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, e.inst);
    end else begin
      chk("empty_pc", inst_pc, last_pc);
      chk("empty_fields", {funct7, rs2, rs1, funct3, rd, opcode}, last_word);
    end
    pop = (m_cnt != 0) && inst_ready;
    if (pop) begin
      e = exp_q.pop_front();
      last_pc = e.pc;
      last_word = e.inst;
      pop_cnt++;
      if (e.pc == 32'h10) begin
        chk("sub_opcode", opcode, OPC_RTYPE);
        chk("sub_rd", rd, 5'd3);
        chk("sub_funct3", funct3, 3'd0);
        chk("sub_rs1", rs1, 5'd1);
        chk("sub_rs2", rs2, 5'd2);
        chk("sub_funct7", funct7, 7'h20);
      end
    end
    if (m_cnt != 0 && !inst_ready) stall_cnt++;
    if (w_req_valid) begin
      chk("wrap_addr", w_req_addr, w_exp);
      w_exp += 32'd4;
      w_acc++;
    end
    rsp_now = imem_rsp_valid;
    @(posedge clk);
    m_out  = m_out + int'(acc) - int'(rsp_now);
    m_cnt  = m_cnt + int'(rsp_now) - int'(pop);
    m_hold = exp_valid && !imem_req_ready;
    m_en   = 1'b1;
    @(negedge clk);
    if (pend_q.size() > 0) begin
      a = pend_q.pop_front();
      d = (a == 32'h10) ? 32'h4020_81B3 : $urandom();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      exp_q.push_back({a, d});
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Reset abandons everything in flight, including a response being driven.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0);
    chk("rst_wrap_valid", w_req_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    exp_q.delete();
    pend_q.delete();
    m_out = 0; m_cnt = 0; m_en = 1'b0; m_hold = 1'b0;
    exp_addr = 32'h0; w_exp = 32'hFFFF_FFFC; w_acc = 0;
    last_pc = 32'h0; last_word = 32'h0;
    pop_cnt = 0; stall_cnt = 0; acc_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout watchdog");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0; w_inst_ready = 1'b0;
    obs_valid = 1'b0; obs_addr = '0;
    do_reset();

    // Decode stalled: only DEPTH requests may go out
    a0 = acc_cnt;
    repeat (10) tick();
    chk("stall_accepts", acc_cnt - a0, DEPTH);
    inst_ready = 1'b1;

    // Sustained stream, then random back-pressure on both sides
    repeat (16) tick();
    repeat (24) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    inst_ready = 1'b1;

    // Memory not ready while fetch_en drops: request must hold, then stop
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 10 && !obs_valid; i++) tick();
    chk("hold_seen", obs_valid, 1'b1);
    held_addr = obs_addr;
    fetch_en = 1'b0;
    a0 = acc_cnt;
    repeat (4) begin
      tick();
      chk("hold_valid", obs_valid, 1'b1);
      chk("hold_addr", obs_addr, held_addr);
    end
    imem_req_ready = 1'b1;
    repeat (5) tick();
    chk("hold_accepts", acc_cnt - a0, 1);

    // Reset with one request outstanding
    fetch_en = 1'b1;
    for (int i = 0; i < 10 && m_out != 1; i++) tick();
    do_reset();
    repeat (2) tick();
    chk("restart_addr", obs_addr, 32'h0);
    repeat (14) begin
      inst_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    inst_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, pop_cnt);
    chk("perf_stall", perf_stall_cnt, stall_cnt);
`endif

    // Drain
    fetch_en = 1'b0;
    for (int i = 0; i < 20 && (m_cnt != 0 || m_out != 0); i++) tick();
    tick();
    chk("drain_empty", inst_valid, 1'b0);
    chk("wrap_accepts", w_acc, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
